// File: rtl/fib_pkg.sv
// Shared widths and helpers for the Fibonacci engine (controller, datapath, stack).
// Pure declarations: no logic, no latency.
// Keeps stack entry width and occupancy-count width consistent across the blocks.
package fib_pkg;

  // Default width of one stack entry (the value of n)
  localparam int FIB_DATA_W = 8;
  // Default number of stack entries
  localparam int FIB_DEPTH  = 16;

  // Occupancy count must represent 0..depth inclusive
  function automatic int fib_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Storage address must represent 0..depth-1; never narrower than one bit
  function automatic int fib_addr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // Decoded per-edge stack operation, listed from highest to lowest priority
  typedef enum logic [2:0] {
    OP_CLR        = 3'd0,  // synchronous clear, push/pop ignored
    OP_OVERWRITE  = 3'd1,  // push&pop on non-empty: replace top in place
    OP_PUSH_EMPTY = 3'd2,  // push&pop on empty: push, flag underflow
    OP_PUSH       = 3'd3,  // push with room
    OP_PUSH_FULL  = 3'd4,  // push while full: dropped, flag overflow
    OP_POP        = 3'd5,  // pop with data
    OP_POP_EMPTY  = 3'd6,  // pop while empty: dropped, flag underflow
    OP_HOLD       = 3'd7   // nothing requested
  } stack_op_e;

endpackage

// File: rtl/fib_stack_mem.sv
// Register file for the operand stack: DEPTH x DATA_W, one write port, one read port.
// Write lands on the rising edge; read is combinational from raddr.
// No backpressure; the array has no reset, so contents are don't-care until written.
module fib_stack_mem
  import fib_pkg::*;
#(
  parameter int DATA_W = FIB_DATA_W,
  parameter int DEPTH  = FIB_DEPTH,
  parameter int ADDR_W = fib_addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Single synchronous write port; the owner guarantees waddr < DEPTH
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  // Asynchronous read so the top of stack is visible without extra latency
  assign rdata = r_mem[raddr];

endmodule

// File: rtl/fib_stack.sv
// LIFO operand stack holding pending n values for the recursive Fibonacci engine.
// Ops take effect on the rising edge; dout/empty/full reflect them combinationally after.
// No backpressure: over/underflowing ops are dropped and latched in sticky ovf/unf flags.
module fib_stack
  import fib_pkg::*;
#(
  parameter  int DATA_W = FIB_DATA_W,
  parameter  int DEPTH  = FIB_DEPTH,
  localparam int CNT_W  = fib_cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              CLR,
  input  logic              clr,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic [CNT_W-1:0]  count,
  output logic              ovf,
  output logic              unf
);

  localparam int ADDR_W = fib_addr_w(DEPTH);

  logic [CNT_W-1:0]  r_count;
  logic              r_ovf;
  logic              r_unf;

  logic              w_empty;
  logic              w_full;
  stack_op_e         w_op;
  logic [ADDR_W-1:0] w_cnt_addr;   // next free slot (valid while not full)
  logic [ADDR_W-1:0] w_top_addr;   // current top slot (valid while not empty)
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [ADDR_W-1:0] w_raddr;
  logic [DATA_W-1:0] w_rdata;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(DEPTH));

  // Address arithmetic is done modulo 2^ADDR_W: count-1 always lies in
  // 0..DEPTH-1, so the truncated subtraction is exact even when count==DEPTH
  // wraps to zero in the low bits (power-of-two depths).
  assign w_cnt_addr = r_count[ADDR_W-1:0];
  assign w_top_addr = w_cnt_addr - ADDR_W'(1);

  // Resolve the request into exactly one operation; clr dominates everything
  always_comb begin
    w_op = OP_HOLD;
    if (clr) begin
      w_op = OP_CLR;
    end else if (push && pop) begin
      w_op = w_empty ? OP_PUSH_EMPTY : OP_OVERWRITE;
    end else if (push) begin
      w_op = w_full ? OP_PUSH_FULL : OP_PUSH;
    end else if (pop) begin
      w_op = w_empty ? OP_POP_EMPTY : OP_POP;
    end
  end

  // Write-port steering: overwrite hits the top slot, push hits the next free one
  always_comb begin
    w_we    = 1'b0;
    w_waddr = w_cnt_addr;
    unique case (w_op)
      OP_OVERWRITE: begin
        w_we    = 1'b1;
        w_waddr = w_top_addr;
      end
      OP_PUSH_EMPTY: begin
        w_we    = 1'b1;
        w_waddr = '0;
      end
      OP_PUSH: begin
        w_we    = 1'b1;
        w_waddr = w_cnt_addr;
      end
      default: begin
        w_we    = 1'b0;
        w_waddr = w_cnt_addr;
      end
    endcase
  end

  // Occupancy count and sticky error flags; popped entries stay in storage
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      unique case (w_op)
        OP_CLR: begin
          r_count <= '0;
          r_ovf   <= 1'b0;
          r_unf   <= 1'b0;
        end
        OP_PUSH_EMPTY: begin
          r_count <= CNT_W'(1);
          r_unf   <= 1'b1;
        end
        OP_PUSH: begin
          r_count <= r_count + CNT_W'(1);
        end
        OP_PUSH_FULL: begin
          r_ovf   <= 1'b1;
        end
        OP_POP: begin
          r_count <= r_count - CNT_W'(1);
        end
        OP_POP_EMPTY: begin
          r_unf   <= 1'b1;
        end
        default: begin
          r_count <= r_count;
        end
      endcase
    end
  end

  // Read the top slot; park the address at zero when empty (output is masked anyway)
  assign w_raddr = w_empty ? '0 : w_top_addr;

  fib_stack_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (w_we),
    .waddr (w_waddr),
    .wdata (din),
    .raddr (w_raddr),
    .rdata (w_rdata)
  );

  // Mask the read data when empty so dout never carries stale or unknown storage
  assign dout  = w_empty ? '0 : w_rdata;
  assign empty = w_empty;
  assign full  = w_full;
  assign count = r_count;
  assign ovf   = r_ovf;
  assign unf   = r_unf;

endmodule
